// File: rtl/pls_pkg.sv
// Shared constants, state type and helpers for the PL Gold-code scrambler.
package pls_pkg;

    localparam int PLS_LFSR_W = 18;
    localparam logic [PLS_LFSR_W-1:0] PLS_X_INIT = 18'h00001;
    localparam logic [PLS_LFSR_W-1:0] PLS_Y_INIT = 18'h3ffff;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_RUN  = 2'd2
    } pls_state_t;

    // Negate a w-bit two's-complement value held in 32 bits; the most negative value clamps to max.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        lo = -(32'sd1 <<< (w - 1));
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        return (v == lo) ? hi : -v;
    endfunction

    function automatic logic [PLS_LFSR_W-1:0] x_step(input logic [PLS_LFSR_W-1:0] x);
        return {x[7] ^ x[0], x[PLS_LFSR_W-1:1]};
    endfunction

    function automatic logic [PLS_LFSR_W-1:0] y_step(input logic [PLS_LFSR_W-1:0] y);
        return {y[10] ^ y[7] ^ y[5] ^ y[0], y[PLS_LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/pls_gold_gen.sv
// Gold sequence generator: x/y LFSRs, seek to code index n, and the 2-bit rotation index R.
module pls_gold_gen
    import pls_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  seek_start,
    input  logic [PLS_LFSR_W-1:0] gold_n,
    input  logic                  seek_en,
    output logic                  seek_done,
    input  logic                  sym_load,
    input  logic                  sym_step,
    output logic [1:0]            r
);

    logic [PLS_LFSR_W-1:0] x_reg;
    logic [PLS_LFSR_W-1:0] y_reg;
    logic [PLS_LFSR_W-1:0] x_seed_reg;
    logic [PLS_LFSR_W-1:0] cnt_reg;
    logic [PLS_LFSR_W-1:0] n_reg;
    logic [PLS_LFSR_W-1:0] x_adv;
    logic [PLS_LFSR_W-1:0] src_x;
    logic [PLS_LFSR_W-1:0] src_y;
    logic                  more_steps;

    // The seek finishes in the cycle that performs the last step, so n steps take n cycles.
    assign more_steps = (cnt_reg != n_reg);
    assign seek_done  = !more_steps || ((cnt_reg + 18'd1) == n_reg);
    assign x_adv      = x_step(x_reg);

    // A frame start uses the reloaded registers for its own symbol.
    assign src_x = sym_load ? x_seed_reg : x_reg;
    assign src_y = sym_load ? PLS_Y_INIT : y_reg;

    assign r = {src_x[4] ^ src_x[6] ^ src_x[15] ^ src_y[5] ^ src_y[6] ^ (^src_y[15:8]),
                src_x[0] ^ src_y[0]};

    always_ff @(posedge clk) begin
        if (srst) begin
            x_reg      <= PLS_X_INIT;
            y_reg      <= PLS_Y_INIT;
            x_seed_reg <= PLS_X_INIT;
            cnt_reg    <= '0;
            n_reg      <= '0;
        end else if (seek_start) begin
            x_reg   <= PLS_X_INIT;
            y_reg   <= PLS_Y_INIT;
            cnt_reg <= '0;
            n_reg   <= gold_n;
        end else if (seek_en) begin
            if (more_steps) begin
                x_reg   <= x_adv;
                cnt_reg <= cnt_reg + 18'd1;
            end
            if (seek_done) begin
                x_seed_reg <= more_steps ? x_adv : x_reg;
            end
        end else if (sym_step) begin
            x_reg <= x_step(src_x);
            y_reg <= y_step(src_y);
        end
    end

endmodule

// File: rtl/pl_gold_scrambler.sv
// DVB-S2 style PL Gold-code scrambler with seek, valid/ready streaming and one-cycle output register.
// Optional macro PLS_HEADER_BYPASS_EN passes the first HDR_LEN symbols of each frame unscrambled.
module pl_gold_scrambler
    import pls_pkg::*;
#(
    parameter int W       = 8,
    parameter int HDR_LEN = 90
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [PLS_LFSR_W-1:0] gold_n,
    output logic                  cfg_busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [W-1:0]          in_i,
    input  logic [W-1:0]          in_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic [W-1:0]          out_i,
    output logic [W-1:0]          out_q
);

    pls_state_t state_reg;
    pls_state_t state_next;

    logic        accept;
    logic        seek_done;
    logic        sym_load;
    logic        sym_step;
    logic [1:0]  r_gen;
    logic [1:0]  r_eff;
    logic [W-1:0] rot_i;
    logic [W-1:0] rot_q;
    logic signed [W-1:0] comp [2];
    logic signed [W-1:0] neg  [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cfg_start) state_next = ST_SEEK;
            ST_SEEK: begin
                if (cfg_start)      state_next = ST_SEEK;
                else if (seek_done) state_next = ST_RUN;
            end
            ST_RUN:  if (cfg_start) state_next = ST_SEEK;
            default: state_next = ST_IDLE;
        endcase
    end

    assign cfg_busy = (state_reg == ST_SEEK);
    assign in_ready = (state_reg == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    pls_gold_gen u_gold_gen (
        .clk        (clk),
        .srst       (rst),
        .seek_start (cfg_start),
        .gold_n     (gold_n),
        .seek_en    ((state_reg == ST_SEEK) && !cfg_start),
        .seek_done  (seek_done),
        .sym_load   (sym_load),
        .sym_step   (sym_step),
        .r          (r_gen)
    );

`ifdef PLS_HEADER_BYPASS_EN
    localparam int HCW = $clog2(HDR_LEN + 2);
    localparam logic [HCW-1:0] HDR_END = HCW'(HDR_LEN);

    logic [HCW-1:0] hdr_cnt_reg;
    logic [HCW-1:0] sym_idx;
    logic           in_hdr;

    // Index of the current symbol within its frame; saturates one past the header.
    assign sym_idx  = in_sof ? '0 : hdr_cnt_reg;
    assign in_hdr   = (sym_idx < HDR_END);
    assign sym_load = accept && (sym_idx == HDR_END);
    assign sym_step = accept && !in_hdr;
    assign r_eff    = in_hdr ? 2'd0 : r_gen;

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_reg <= '0;
        end else if (accept) begin
            if (in_sof)                    hdr_cnt_reg <= HCW'(1);
            else if (hdr_cnt_reg <= HDR_END) hdr_cnt_reg <= hdr_cnt_reg + HCW'(1);
        end
    end
`else
    assign sym_load = accept && in_sof;
    assign sym_step = accept;
    assign r_eff    = r_gen;
`endif

    assign comp[0] = in_i;
    assign comp[1] = in_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_neg
            assign neg[gi] = W'(sat_neg(32'(comp[gi]), W));
        end
    endgenerate

    always_comb begin
        rot_i = in_i;
        rot_q = in_q;
        case (r_eff)
            2'd1: begin rot_i = neg[1]; rot_q = in_i;   end
            2'd2: begin rot_i = neg[0]; rot_q = neg[1]; end
            2'd3: begin rot_i = in_q;   rot_q = neg[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sof   <= in_sof;
            out_i     <= rot_i;
            out_q     <= rot_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pl_gold_scrambler.sv
// Self-checking bench for pl_gold_scrambler against a sequence-level Gold-code model.
module tb_pl_gold_scrambler;

    localparam int HDR   = 90;
    localparam int MAXK  = 2400;
    localparam int XL    = 300 + MAXK + 24;
    localparam int YL    = MAXK + 24;
    localparam int MAXG  = 2100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [17:0] gold_n;
    logic        cfg_busy;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [7:0]  in_i;
    logic [7:0]  in_q;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic [7:0]  out_i;
    logic [7:0]  out_q;

    int checks = 0;
    int errors = 0;

    bit         xs [XL];
    bit         ys [YL];
    bit   [1:0] rseq [MAXK];
    logic [16:0] exp_q [$];
    logic [16:0] got [MAXG];
    logic [16:0] ref_log [MAXG];
    int          got_n;
    int          sym_j;

    pl_gold_scrambler dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .gold_n    (gold_n),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_i     (out_i),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Gold sequence as bit streams: x(i+18)=x(i+7)^x(i), y(i+18)=y(i+10)^y(i+7)^y(i+5)^y(i).
    task automatic build_model(input int n);
        for (int i = 0; i < 18; i++) begin
            xs[i] = (i == 0);
            ys[i] = 1'b1;
        end
        for (int i = 0; i + 18 < XL; i++) xs[i+18] = xs[i+7] ^ xs[i];
        for (int i = 0; i + 18 < YL; i++) ys[i+18] = ys[i+10] ^ ys[i+7] ^ ys[i+5] ^ ys[i];
        for (int k = 0; k < MAXK; k++) begin
            bit zi, zq;
            zi = xs[n+k] ^ ys[k];
            zq = xs[n+k+4] ^ xs[n+k+6] ^ xs[n+k+15] ^ ys[k+5] ^ ys[k+6];
            for (int t = 8; t <= 15; t++) zq ^= ys[k+t];
            rseq[k] = {zq, zi};
        end
    endtask

    function automatic int exp_r(input int j);
        int jj;
        jj = j;
`ifdef PLS_HEADER_BYPASS_EN
        if (jj < HDR) return 0;
        jj = jj - HDR;
`endif
        if (jj >= MAXK) return 0;
        return int'(rseq[jj]);
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [15:0] rot_model(input int r, input int i, input int q);
        int oi, oq;
        case (r)
            1:       begin oi = sat8(-q); oq = i;        end
            2:       begin oi = sat8(-i); oq = sat8(-q); end
            3:       begin oi = q;        oq = sat8(-i); end
            default: begin oi = i;        oq = q;        end
        endcase
        return {8'(oi), 8'(oq)};
    endfunction

    task automatic do_seek(input int n, output int busy);
        build_model(n);
        @(negedge clk);
        gold_n    = 18'(n);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        busy = 0;
        for (int c = 0; c < n + 20; c++) begin
            if (cfg_busy !== 1'b1) break;
            busy++;
            @(negedge clk);
        end
    endtask

    // Streams nsym symbols; every output is checked against the model and logged in order.
    task automatic stream(input int nsym, input int sof_period, input int valid_pct,
                          input int ready_pct, input int stall_at, input bit fixed,
                          input int fi, input int fq);
        int sent, cyc, limit;
        bit hold_prev;
        logic [16:0] hold_val, obs;
        sent = 0; cyc = 0; hold_prev = 0; hold_val = '0;
        got_n = 0;
        limit = nsym * 30 + 200;
        while ((sent < nsym || exp_q.size() > 0) && cyc < limit) begin
            @(negedge clk);
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 99) < ready_pct);
            cyc++;
            obs = {out_sof, out_i, out_q};
            checks++;
            if (out_valid !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL out_valid: got %b required %b", out_valid, exp_q.size() > 0);
            end
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== hold_val) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h", out_valid, obs, hold_val);
                end
            end
            if (out_valid === 1'b1 && exp_q.size() > 0 && out_ready) begin
                checks++;
                if (obs !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_data[%0d]: got %h required %h", got_n, obs, exp_q[0]);
                end
                if (got_n < MAXG) got[got_n] = obs;
                got_n++;
                void'(exp_q.pop_front());
            end
            hold_prev = (out_valid === 1'b1) && !out_ready;
            hold_val  = obs;
            if (sent < nsym && $urandom_range(0, 99) < valid_pct) begin
                int di, dq;
                di = fixed ? fi : int'($urandom_range(0, 255)) - 128;
                dq = fixed ? fq : int'($urandom_range(0, 255)) - 128;
                in_valid = 1'b1;
                in_sof   = (sent == 0) || (sof_period > 0 && (sent % sof_period) == 0);
                in_i     = 8'(di);
                in_q     = 8'(dq);
                #1;
                if (in_ready === 1'b1) begin
                    sym_j = in_sof ? 0 : sym_j + 1;
                    exp_q.push_back({in_sof, rot_model(exp_r(sym_j), di, dq)});
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                #1;
            end
            checks++;
            if (in_ready !== (exp_q.size() <= 1 && (exp_q.size() == 0 || out_ready || in_valid))) begin
                // in_ready was sampled before the push; recompute from the pre-push view below
            end
            if (in_ready !== ((exp_q.size() - ((in_valid && in_ready) ? 1 : 0)) == 0 || out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b required %b", in_ready, !in_ready);
            end
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != nsym || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_done: sent %0d of %0d, %0d outputs pending", sent, nsym, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_sof, out_i, out_q, cfg_busy, in_ready} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%b i=%h q=%h busy=%b rdy=%b required all 0",
                     out_valid, out_sof, out_i, out_q, cfg_busy, in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_accept: got rdy=%b v=%b required 0 0", in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_first_symbol();
        int busy;
        do_seek(0, busy);
        checks++;
        if (busy != 1) begin
            errors++;
            $display("FAIL busy_n0: got %0d cycles required 1", busy);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        in_i      = 8'd40;
        in_q      = 8'hec;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        checks++;
        if ({out_valid, out_sof, out_i, out_q} !== {1'b1, 1'b1, 8'd40, 8'hec}) begin
            errors++;
            $display("FAIL first_symbol: got v=%b s=%b (%0d,%0d) required v=1 s=1 (40,-20)",
                     out_valid, out_sof, $signed(out_i), $signed(out_q));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random_gold0();
        int busy;
        do_seek(0, busy);
        checks++;
        if (busy != 1) begin
            errors++;
            $display("FAIL busy_n0b: got %0d required 1", busy);
        end
        stream(2000, 0, 70, 70, -1, 1'b0, 0, 0);
    endtask

    task automatic test_gold5();
        int busy;
        do_seek(5, busy);
        checks++;
        if (busy != 5) begin
            errors++;
            $display("FAIL busy_n5: got %0d cycles required 5", busy);
        end
        stream(2000, 700, 70, 70, -1, 1'b0, 0, 0);
    endtask

    task automatic test_saturation();
        int k1, k2, off, len;
        k1 = -1; k2 = -1;
        for (int k = 0; k < 200; k++) begin
            if (k1 < 0 && rseq[k] == 2'd1) k1 = k;
            if (k2 < 0 && rseq[k] == 2'd2) k2 = k;
        end
`ifdef PLS_HEADER_BYPASS_EN
        off = HDR;
`else
        off = 0;
`endif
        checks++;
        if (k1 < 0 || k2 < 0) begin
            errors++;
            $display("FAIL sat_search: got k1=%0d k2=%0d required both found", k1, k2);
        end else begin
            len = off + ((k1 > k2) ? k1 : k2) + 1;
            stream(len, 0, 100, 100, -1, 1'b1, -128, 127);
            checks++;
            if (got[off+k2][15:0] !== {8'h7f, 8'h81}) begin
                errors++;
                $display("FAIL sat_r2: got %h required 7f81", got[off+k2][15:0]);
            end
            checks++;
            if (got[off+k1][15:0] !== {8'h81, 8'h80}) begin
                errors++;
                $display("FAIL sat_r1: got %h required 8180", got[off+k1][15:0]);
            end
        end
    endtask

    task automatic test_stall();
        int busy;
        do_seek(9, busy);
        checks++;
        if (busy != 9) begin
            errors++;
            $display("FAIL busy_n9: got %0d required 9", busy);
        end
        stream(400, 0, 100, 100, 150, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        stream(600, 300, 80, 80, -1, 1'b1, 3, 5);
        for (int j = 0; j < 300; j++) begin
            checks++;
            if (got[j+300][15:0] !== got[j][15:0]) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h required %h", j, got[j+300][15:0], got[j][15:0]);
            end
        end
    endtask

    task automatic test_restart_seek();
        int busy;
        @(negedge clk);
        gold_n    = 18'd100;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        do_seek(5, busy);
        checks++;
        if (busy != 5) begin
            errors++;
            $display("FAIL busy_restart: got %0d required 5", busy);
        end
        stream(300, 0, 70, 70, -1, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_seek();
        int busy;
        do_seek(7, busy);
        stream(200, 0, 100, 100, -1, 1'b1, 3, 5);
        for (int j = 0; j < 200; j++) ref_log[j] = got[j];
        @(negedge clk);
        gold_n    = 18'd150;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_busy, in_ready, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_seek: got busy=%b rdy=%b v=%b required 0 0 0", cfg_busy, in_ready, out_valid);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_accept: got in_ready=%b required 0", in_ready);
            end
        end
        in_valid = 1'b0;
        do_seek(7, busy);
        checks++;
        if (busy != 7) begin
            errors++;
            $display("FAIL busy_after_reset: got %0d required 7", busy);
        end
        stream(200, 0, 60, 60, -1, 1'b1, 3, 5);
        for (int j = 0; j < 200; j++) begin
            checks++;
            if (got[j] !== ref_log[j]) begin
                errors++;
                $display("FAIL reset_repeat[%0d]: got %h required %h", j, got[j], ref_log[j]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; gold_n = '0;
        in_valid = 1'b0; in_sof = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b1;
        sym_j = 0; got_n = 0;
        test_reset();
        test_first_symbol();
        test_random_gold0();
        test_gold5();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_restart_seek();
        test_reset_mid_seek();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pl_gold_scrambler.md
PL_GOLD_SCRAMBLER -- requirements
Module: pl_gold_scrambler

Interface
REQ-001 Parameter W, default 8: signed two's-complement width of each I/Q sample component.
REQ-002 Parameter HDR_LEN, default 90: PLHEADER length in symbols.
REQ-003 clk  input  1  single clock; every register SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_start  input  1  one-cycle pulse that loads gold_n and starts the seek.
REQ-006 gold_n  input  18  Gold code index n, sampled when cfg_start=1.
REQ-007 cfg_busy  output  1  high while the seek is in progress.
REQ-008 in_valid / in_ready  input / output  1 / 1  input symbol handshake.
REQ-009 in_sof  input  1  first symbol of a PL frame, qualified by in_valid.
REQ-010 in_i, in_q  input  W each  input symbol components.
REQ-011 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-012 out_sof  output  1  in_sof delayed alongside its symbol.
REQ-013 out_i, out_q  output  W each  scrambled symbol components.

Function
REQ-014 States: IDLE (in_ready=0), SEEK (in_ready=0, cfg_busy=1) and RUN.
REQ-015 Transitions:
- IDLE -> SEEK on cfg_start.
- SEEK -> RUN when the step counter equals gold_n; gold_n=0 enters RUN the next cycle.
- RUN -> SEEK on cfg_start; any output already registered SHALL still drain.
REQ-016 x LFSR, 18 bits: init x[0]=1, all other bits 0; step x(i+18) = x(i+7) xor x(i).
REQ-017 y LFSR, 18 bits: init all ones; step y(i+18) = y(i+10) xor y(i+7) xor y(i+5) xor y(i).
REQ-018 SEEK SHALL advance x one step per clock, gold_n steps in total, then store the result as x_seed; y is not advanced.
REQ-019 A symbol is accepted when in_valid and in_ready are both high; x and y SHALL step once per scrambled symbol accepted, never otherwise.
REQ-020 On an accepted symbol with in_sof=1:
- x SHALL be reloaded with x_seed and y with all ones, applied before that frame's first scrambled symbol.
- The header counter SHALL reset to 0.
REQ-021 Scrambling index for each symbol:
- zI = x[0] xor y[0].
- zQ = (x[4] xor x[6] xor x[15]) xor (y[5] xor y[6] xor y[8] xor ... xor y[15]).
- R = 2*zQ + zI.
REQ-022 Rotation by R:
- R=0: out = (I, Q).
- R=1: out = (-Q, I).
- R=2: out = (-I, -Q).
- R=3: out = (Q, -I).
REQ-023 Negation SHALL saturate: the negation of -2^(W-1) is 2^(W-1)-1, with no wrap-around.
REQ-024 Latency SHALL be exactly one cycle from acceptance to out_valid, through a single output register.
REQ-025 in_ready SHALL equal (state==RUN) and (not out_valid or out_ready).
REQ-026 While out_valid=1 and out_ready=0, the out_* values SHALL remain stable.
REQ-027 A cfg_start that arrives during SEEK SHALL restart the seek with the new gold_n.

Reset
REQ-028 While rst is high the block SHALL be in IDLE, with the following values:
- out_valid=0, out_sof=0, out_i=0, out_q=0, cfg_busy=0, in_ready=0.
- x and x_seed at their x init value, y all ones, header counter 0.
REQ-029 Reset asserted in the middle of a seek or a frame SHALL abandon it; after reset, no symbol is accepted until a new cfg_start seek completes.

Configuration
REQ-030 Macro PLS_HEADER_BYPASS_EN.
- Defined: the first HDR_LEN symbols from in_sof onward SHALL pass with R forced to 0. The LFSRs SHALL not step during those symbols and SHALL be reloaded per REQ-020 on the first data symbol after them. A new in_sof during the header SHALL restart the count.
- Undefined: in_sof marks the first data symbol, and every symbol is scrambled.

Structure
REQ-031 A shared package pls_pkg SHALL hold:
- The LFSR width constant (18) and both init constants.
- The state enum type.
- The saturating negate function.
REQ-032 A sub-module pls_gold_gen SHALL contain both LFSRs, x_seed, the seek counter and the R output, with load, step and seek controls.

Verification
REQ-033 gold_n=0, cfg_start, wait until cfg_busy=0; then in_sof with (I,Q)=(40,-20) -> first output R=0, so out=(40,-20) (under PLS_HEADER_BYPASS_EN, the 91st symbol).
REQ-034 gold_n=0 and gold_n=5, 2000 symbols each, compared against the bit-exact reference model of REQ-016..022 -> zero mismatches; cfg_busy high for exactly 5 cycles for gold_n=5.
REQ-035 W=8, input (-128, 127) forced through R=2 -> (127, -127); R=1 -> (-127, -128).
REQ-036 out_ready held low for 10 cycles mid-frame -> out_* stable, in_ready=0, and no LFSR step (the sequence continues without a gap afterwards).
REQ-037 Two frames back to back with in_sof -> the second frame's R sequence is identical to the first's.
REQ-038 rst asserted during SEEK, then cfg_start -> the seek restarts from the x init value and the same R sequence is produced as after a clean start.
